// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: STAGES-deep register chain with valid/ready handshake,
// backpressure, bubble collapse and targeted kill of younger stages.
// Stage 0 is the youngest (input side); stage STAGES-1 drives the output.
// Optional feature macro: PIPE_STAGE_CHAIN_PERF_EN
//   defined   -> saturating stall and kill performance counters
//   undefined -> perf_stall_cnt / perf_kill_cnt tied to 0, no counter flops

// One register stage: loads when ldEn, is cleared by killEn.
module pipe_stage_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ldEn,
  input  logic             killEn,
  input  logic             srcValid,
  input  logic [WIDTH-1:0] srcData,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Kill wins over load; payload only moves with a valid item so idle
  // stages keep their last data and do not toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (killEn)      valid <= 1'b0;
      else if (ldEn)   valid <= srcValid;
      if (!killEn && ldEn && srcValid) data <= srcData;
    end
  end

endmodule

module pipe_stage_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,   // must be >= 2
  parameter int CNT_W  = 16,
  localparam int OCC_W = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  input  logic [STAGES-1:0] kill,
  output logic [STAGES-1:0] stage_valid,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_kill_cnt
);

  logic [STAGES-1:0]            validQ;
  logic [STAGES-1:0][WIDTH-1:0] dataQ;
  logic [STAGES-1:0]            rdy;
  logic [STAGES-1:0]            killMask;
  logic [STAGES-1:0]            srcValid;
  logic [STAGES-1:0][WIDTH-1:0] srcData;
  logic [OCC_W-1:0]             occCount;

  // Per-stage control and the register instances.
  // rdy[i] is the unrolled form of rdy[i] = rdy[i+1] | ~validQ[i]: a stage can
  // accept if the output drains or any stage from i upward is empty. Writing it
  // flat keeps the vector free of bit-to-bit combinational dependencies.
  // killMask[i] is set when some kill bit at index >= i is set, i.e. stage i
  // lies at or below the highest killed index.
  for (genvar i = 0; i < STAGES; i++) begin : gStage
    assign rdy[i]      = out_ready | ~&validQ[STAGES-1:i];
    assign killMask[i] = |kill[STAGES-1:i];

    if (i == 0) begin : gSrcIn
      assign srcValid[i] = in_valid & in_ready;
      assign srcData[i]  = in_data;
    end else begin : gSrcPrev
      // A killed predecessor hands over a bubble instead of its item.
      assign srcValid[i] = validQ[i-1] & ~killMask[i-1];
      assign srcData[i]  = dataQ[i-1];
    end

    pipe_stage_reg #(.WIDTH(WIDTH)) uStage (
      .clk      (clk),
      .rst_n    (rst_n),
      .ldEn     (rdy[i]),
      .killEn   (killMask[i]),
      .srcValid (srcValid[i]),
      .srcData  (srcData[i]),
      .valid    (validQ[i]),
      .data     (dataQ[i])
    );
  end

  // Input is refused during any kill so a fresh item never lands in a killed stage.
  assign in_ready    = rdy[0] & ~|kill;
  assign out_valid   = validQ[STAGES-1];
  assign out_data    = dataQ[STAGES-1];
  assign stage_valid = validQ;
  assign occupancy   = occCount;

  // Occupancy is a popcount of registered valid bits only.
  always_comb begin
    occCount = '0;
    for (int i = 0; i < STAGES; i++) occCount = occCount + OCC_W'(validQ[i]);
  end

`ifdef PIPE_STAGE_CHAIN_PERF_EN
  logic [CNT_W-1:0] stallCntQ;
  logic [CNT_W-1:0] killCntQ;
  logic [OCC_W-1:0] killPop;
  logic [CNT_W:0]   killSum;

  // Number of valid items discarded this cycle (stages 0..j are exactly killMask).
  always_comb begin
    killPop = '0;
    for (int i = 0; i < STAGES; i++) killPop = killPop + OCC_W'(validQ[i] & killMask[i]);
  end

  assign killSum = {1'b0, killCntQ} + (CNT_W+1)'(killPop);

  // Saturating counters: stalled input cycles and discarded items.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCntQ <= '0;
      killCntQ  <= '0;
    end else begin
      if (in_valid && !in_ready && !(&stallCntQ)) stallCntQ <= stallCntQ + CNT_W'(1);
      if (|kill) killCntQ <= killSum[CNT_W] ? '1 : killSum[CNT_W-1:0];
    end
  end

  assign perf_stall_cnt = stallCntQ;
  assign perf_kill_cnt  = killCntQ;
`else
  assign perf_stall_cnt = '0;
  assign perf_kill_cnt  = '0;
`endif

endmodule
